// File: rtl/frame_stream_scheduler.sv
// Frame-granular scheduler: tracks FIFO level, throttles producer writes, streams reads in whole frames.
// Latency: write gating is combinational; PRIME->STREAM takes one cycle after the level reaches the start mark.
// Backpressure: wr_ready_o drops at the high mark until the level falls to the release mark; reads wait on rd_ready_i/empty.
module frame_stream_scheduler #(
  parameter int FRAME_SIZE   = 1280,
  parameter int UPPER_FRAMES = 10,
  parameter int LOWER_FRAMES = 2,
  parameter int CNT_W        = 21
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             wr_req_i,
  output logic             wr_ready_o,
  output logic             fifo_wr_en_o,
  input  logic             rd_ready_i,
  output logic             fifo_rd_en_o,
  input  logic             fifo_full_i,
  input  logic             fifo_empty_i,
  output logic [CNT_W-1:0] fill_count_o,
  output logic             throttle_o,
  output logic [1:0]       state_o,
  output logic [15:0]      frames_sent_o
);

  localparam int WPOS_W = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;

  // Level thresholds in words
  localparam logic [CNT_W-1:0] HI    = CNT_W'(UPPER_FRAMES * FRAME_SIZE);
  localparam logic [CNT_W-1:0] REL   = CNT_W'((UPPER_FRAMES - 1) * FRAME_SIZE);
  localparam logic [CNT_W-1:0] START = CNT_W'((LOWER_FRAMES + 1) * FRAME_SIZE);
  localparam logic [CNT_W-1:0] LO    = CNT_W'(LOWER_FRAMES * FRAME_SIZE);
  localparam logic [WPOS_W-1:0] LAST_POS = WPOS_W'(FRAME_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_fill_count;
  logic [CNT_W-1:0]  w_count_next;
  logic              r_throttle;
  logic [WPOS_W-1:0] r_wpos;
  logic [15:0]       r_frames_sent;
  logic              w_wr_ready;
  logic              w_wr_en;
  logic              w_rd_en;
  logic              w_last_word;

  // Producer side never depends on FSM state, only on throttle and FIFO full
  assign w_wr_ready   = !r_throttle && !fifo_full_i;
  assign w_wr_en      = wr_req_i && w_wr_ready;
  assign w_count_next = r_fill_count + {{(CNT_W-1){1'b0}}, w_wr_en}
                                     - {{(CNT_W-1){1'b0}}, w_rd_en};
  assign w_last_word  = w_rd_en && (r_wpos == LAST_POS);

  // Next-state and read-enable decode; frame boundaries are the only exit from STREAM
  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable_i) w_state_next = PRIME;
      end
      PRIME: begin
        // A disable wins over reaching the start level
        if (!enable_i)                  w_state_next = IDLE;
        else if (r_fill_count >= START) w_state_next = STREAM;
      end
      STREAM: begin
        // Non-zero level check keeps the counter from underflowing
        w_rd_en = rd_ready_i && !fifo_empty_i && (r_fill_count != '0);
        if (w_last_word) begin
          if (!enable_i)               w_state_next = IDLE;
          else if (w_count_next <= LO) w_state_next = PRIME;
          else                         w_state_next = STREAM;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Word level and throttle hysteresis, both driven from the post-transfer level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fill_count <= '0;
      r_throttle   <= 1'b0;
    end else begin
      r_fill_count <= w_count_next;
      if (w_count_next >= HI)       r_throttle <= 1'b1;
      else if (w_count_next <= REL) r_throttle <= 1'b0;
    end
  end

  // Position within the current frame and completed-frame count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wpos        <= '0;
      r_frames_sent <= '0;
    end else if (w_rd_en) begin
      if (w_last_word) begin
        r_wpos        <= '0;
        r_frames_sent <= r_frames_sent + 16'd1;
      end else begin
        r_wpos <= r_wpos + WPOS_W'(1);
      end
    end
  end

  assign wr_ready_o    = w_wr_ready;
  assign fifo_wr_en_o  = w_wr_en;
  assign fifo_rd_en_o  = w_rd_en;
  assign fill_count_o  = r_fill_count;
  assign throttle_o    = r_throttle;
  assign state_o       = r_state;
  assign frames_sent_o = r_frames_sent;

endmodule

// File: tb/tb_frame_stream_scheduler.sv
// Bench for frame_stream_scheduler with FRAME_SIZE=4, UPPER=4, LOWER=1 (HI=16, REL=12, START=8, LO=4).
// Stimulus pushes the hand-computed level/frame count expected at each FIFO transfer; a monitor pops on every enable.
// State checks (reset, throttle, FSM transitions) are made directly by the stimulus on the falling edge.
module tb_frame_stream_scheduler;

  logic        clk;
  logic        reset;
  logic        enable_i;
  logic        wr_req_i;
  logic        wr_ready_o;
  logic        fifo_wr_en_o;
  logic        rd_ready_i;
  logic        fifo_rd_en_o;
  logic        fifo_full_i;
  logic        fifo_empty_i;
  logic [7:0]  fill_count_o;
  logic        throttle_o;
  logic [1:0]  state_o;
  logic [15:0] frames_sent_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int fill;
    int frames;
  } xfer_t;

  xfer_t wr_q[$];
  xfer_t rd_q[$];

  frame_stream_scheduler #(
    .FRAME_SIZE  (4),
    .UPPER_FRAMES(4),
    .LOWER_FRAMES(1),
    .CNT_W       (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable_i     (enable_i),
    .wr_req_i     (wr_req_i),
    .wr_ready_o   (wr_ready_o),
    .fifo_wr_en_o (fifo_wr_en_o),
    .rd_ready_i   (rd_ready_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .fifo_full_i  (fifo_full_i),
    .fifo_empty_i (fifo_empty_i),
    .fill_count_o (fill_count_o),
    .throttle_o   (throttle_o),
    .state_o      (state_o),
    .frames_sent_o(frames_sent_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int fill);
    xfer_t e;
    e.fill   = fill;
    e.frames = 0;
    wr_q.push_back(e);
  endtask

  task automatic push_rd(input int fill, input int frames);
    xfer_t e;
    e.fill   = fill;
    e.frames = frames;
    rd_q.push_back(e);
  endtask

  // Monitor: every FIFO enable must match the next queued expectation
  always @(negedge clk) begin
    xfer_t e;
    if (fifo_wr_en_o) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = wr_q.pop_front();
        chk("write_fill", int'(fill_count_o), e.fill);
      end
    end
    if (fifo_rd_en_o) begin
      if (rd_q.size() == 0) begin
        chk("unexpected_read", 1, 0);
      end else begin
        e = rd_q.pop_front();
        chk("read_fill", int'(fill_count_o), e.fill);
        chk("read_frames", int'(frames_sent_o), e.frames);
      end
    end
  end

  initial begin
    reset        = 1'b0;
    enable_i     = 1'b0;
    wr_req_i     = 1'b0;
    rd_ready_i   = 1'b0;
    fifo_full_i  = 1'b1;
    fifo_empty_i = 1'b0;

    // Reset state; wr_ready follows fifo_full during reset
    @(negedge clk);
    chk("rst_wr_ready_full", int'(wr_ready_o), 0);
    fifo_full_i = 1'b0;
    #1;
    chk("rst_wr_ready", int'(wr_ready_o), 1);
    chk("rst_fill", int'(fill_count_o), 0);
    chk("rst_throttle", int'(throttle_o), 0);
    chk("rst_state", int'(state_o), 0);
    chk("rst_frames", int'(frames_sent_o), 0);
    chk("rst_rd_en", int'(fifo_rd_en_o), 0);
    chk("rst_wr_en", int'(fifo_wr_en_o), 0);
    nxt();
    reset = 1'b1;

    // Throttle set: 16 writes accepted, then blocked
    enable_i = 1'b1;
    wr_req_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_wr(i);
      nxt();
    end
    @(negedge clk);
    chk("thr_throttle", int'(throttle_o), 1);
    chk("thr_wr_ready", int'(wr_ready_o), 0);
    chk("thr_fill", int'(fill_count_o), 16);
    chk("thr_state", int'(state_o), 2);
    nxt();
    @(negedge clk);
    chk("thr_fill_hold", int'(fill_count_o), 16);
    nxt();
    wr_req_i = 1'b0;

    // Release: 12 reads, throttle clears at 12, drops to PRIME at LO
    rd_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      push_rd(16 - i, i / 4);
      @(negedge clk);
      if (i == 3) begin
        chk("rel_throttle_held", int'(throttle_o), 1);
        chk("rel_fill13", int'(fill_count_o), 13);
      end
      if (i == 4) begin
        chk("rel_throttle_clr", int'(throttle_o), 0);
        chk("rel_frames1", int'(frames_sent_o), 1);
      end
      if (i == 8) chk("rel_state_stream", int'(state_o), 2);
      nxt();
    end
    @(negedge clk);
    chk("lo_state_prime", int'(state_o), 1);
    chk("lo_fill", int'(fill_count_o), 4);
    chk("lo_frames", int'(frames_sent_o), 3);
    chk("lo_rd_en", int'(fifo_rd_en_o), 0);
    nxt();

    // Reset pulse between scenarios
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_fill", int'(fill_count_o), 0);
    chk("rst2_frames", int'(frames_sent_o), 0);
    chk("rst2_state", int'(state_o), 0);
    nxt();
    reset = 1'b1;

    // Prime threshold: 8 writes, STREAM one cycle after the level shows 8
    wr_req_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_wr(i);
      @(negedge clk);
      if (i == 7) chk("prime_state_after7", int'(state_o), 1);
      nxt();
    end
    wr_req_i = 1'b0;
    @(negedge clk);
    chk("prime_fill8", int'(fill_count_o), 8);
    chk("prime_still_prime", int'(state_o), 1);
    chk("prime_no_read", int'(fifo_rd_en_o), 0);
    nxt();
    push_rd(8, 0);
    @(negedge clk);
    chk("prime_stream", int'(state_o), 2);
    chk("prime_first_read", int'(fifo_rd_en_o), 1);
    nxt();

    // Mid-frame stall on empty holds the word position
    push_rd(7, 0);
    nxt();
    fifo_empty_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_no_read", int'(fifo_rd_en_o), 0);
      nxt();
    end
    fifo_empty_i = 1'b0;
    push_rd(6, 0);
    nxt();
    push_rd(5, 0);
    nxt();
    @(negedge clk);
    chk("stall_state_prime", int'(state_o), 1);
    chk("stall_fill", int'(fill_count_o), 4);
    chk("stall_frames", int'(frames_sent_o), 1);
    nxt();

    // Refill to 8, then simultaneous read and write
    wr_req_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_wr(4 + i);
      nxt();
    end
    wr_req_i = 1'b0;
    @(negedge clk);
    chk("refill_prime", int'(state_o), 1);
    nxt();
    wr_req_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_wr(8);
      push_rd(8, 1);
      nxt();
    end
    wr_req_i = 1'b0;

    // Enable drop after word 2: frame completes, then IDLE
    enable_i = 1'b0;
    push_rd(8, 1);
    @(negedge clk);
    chk("simul_fill", int'(fill_count_o), 8);
    nxt();
    push_rd(7, 1);
    @(negedge clk);
    chk("drop_still_stream", int'(state_o), 2);
    nxt();
    @(negedge clk);
    chk("drop_state_idle", int'(state_o), 0);
    chk("drop_frames", int'(frames_sent_o), 2);
    chk("drop_fill", int'(fill_count_o), 6);
    chk("drop_rd_en", int'(fifo_rd_en_o), 0);
    nxt();

    // Reset mid-frame abandons the partial frame
    enable_i = 1'b1;
    wr_req_i = 1'b1;
    push_wr(6);
    nxt();
    push_wr(7);
    nxt();
    wr_req_i = 1'b0;
    nxt();
    push_rd(8, 2);
    nxt();
    push_rd(7, 2);
    nxt();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_fill", int'(fill_count_o), 0);
    chk("mid_rst_state", int'(state_o), 0);
    chk("mid_rst_frames", int'(frames_sent_o), 0);
    chk("mid_rst_rd_en", int'(fifo_rd_en_o), 0);
    nxt();
    reset = 1'b1;

    // Full frame after reset proves the word position restarted at 0
    wr_req_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_wr(i);
      nxt();
    end
    wr_req_i = 1'b0;
    nxt();
    for (int i = 0; i < 4; i++) begin
      push_rd(8 - i, 0);
      nxt();
    end
    @(negedge clk);
    chk("post_rst_frames", int'(frames_sent_o), 1);
    chk("post_rst_state", int'(state_o), 1);
    chk("post_rst_fill", int'(fill_count_o), 4);
    nxt();

    chk("wr_q_drained", wr_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_stream_scheduler.md
# frame_stream_scheduler

Frame-granular read/write scheduler for the frame-buffer FIFO. It tracks the FIFO word level internally, back-pressures the producer with upper-bound hysteresis, and sequences consumer reads in whole frames with lower-bound hysteresis. It sits between the pixel producer, the FIFO write/read enables and the downstream consumer, and drives the FIFO enables directly.

## Interface
- FRAME_SIZE, 1280, words per frame
- UPPER_FRAMES, 10, level in frames at which writes are throttled
- LOWER_FRAMES, 2, level in frames at or below which streaming pauses at a frame boundary
- CNT_W, 21, width of the level counter; must hold UPPER_FRAMES*FRAME_SIZE
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-low reset
- enable_i  in  1  streaming enable from the control register
- wr_req_i  in  1  producer has a word this cycle
- wr_ready_o  out  1  scheduler accepts a producer word this cycle
- fifo_wr_en_o  out  1  FIFO write enable
- rd_ready_i  in  1  downstream can take a word this cycle
- fifo_rd_en_o  out  1  FIFO read enable
- fifo_full_i  in  1  FIFO full flag
- fifo_empty_i  in  1  FIFO empty flag
- fill_count_o  out  CNT_W  internal word level
- throttle_o  out  1  upper-bound hysteresis flag
- state_o  out  2  FSM state: 0 IDLE, 1 PRIME, 2 STREAM
- frames_sent_o  out  16  completed frames read, wraps modulo 2^16

## Operation
- Definitions: HI = UPPER_FRAMES*FRAME_SIZE, REL = (UPPER_FRAMES-1)*FRAME_SIZE, START = (LOWER_FRAMES+1)*FRAME_SIZE, LO = LOWER_FRAMES*FRAME_SIZE.
- Write path, combinational:
  - wr_ready_o = !throttle_o & !fifo_full_i
  - fifo_wr_en_o = wr_req_i & wr_ready_o
- Level counter: count_next = fill_count_o + fifo_wr_en_o - fifo_rd_en_o. Simultaneous read and write leaves the count unchanged. The counter never wraps; a decrement at 0 is blocked by the read gating below.
- Throttle register:
  - Sets when count_next >= HI.
  - Clears when count_next <= REL.
  - Otherwise holds.
- Word-in-frame counter wpos: 0..FRAME_SIZE-1. It increments on each fifo_rd_en_o and wraps to 0 on the last word. The last word is the read with wpos == FRAME_SIZE-1.
- FSM:
  - IDLE: fifo_rd_en_o = 0. Goes to PRIME when enable_i = 1.
  - PRIME: fifo_rd_en_o = 0.
    - Goes to STREAM when fill_count_o >= START.
    - Goes to IDLE when enable_i = 0.
  - STREAM: fifo_rd_en_o = rd_ready_i & !fifo_empty_i & (fill_count_o != 0). A stall mid-frame holds wpos. On the last-word read, frames_sent_o increments, then:
    - enable_i = 0 goes to IDLE.
    - Otherwise, count_next <= LO goes to PRIME.
    - Otherwise, the FSM stays in STREAM.
    - enable_i dropping mid-frame takes effect only at the frame boundary; the frame always completes.
- Writes are independent of FSM state and continue in IDLE and PRIME.

## Timing
- Reset values: fill_count_o 0, throttle_o 0, state_o IDLE, wpos 0, frames_sent_o 0, fifo_rd_en_o 0, fifo_wr_en_o 0. wr_ready_o equals !fifo_full_i during and after reset.
- fill_count_o, throttle_o, state_o, wpos and frames_sent_o all update on the same edge as the accepted transfer.
- Throttle uses count_next, so wr_ready_o is low in the cycle after the write that reaches HI. No write beyond HI is ever accepted.
- PRIME to STREAM: the transition happens on the edge after fill_count_o >= START. The first fifo_rd_en_o can assert in the first STREAM cycle, so latency is 1 cycle.
- Last-word read and state change occur on the same edge. In the next cycle, fifo_rd_en_o = 0 if the new state is not STREAM.
- Reset asserted mid-frame: all state clears immediately and asynchronously, and the partial frame is abandoned.

## Test plan
Each scenario uses FRAME_SIZE=4, UPPER_FRAMES=4, LOWER_FRAMES=1 (HI=16, REL=12, START=8, LO=4).
- Reset: assert reset with fifo_full_i=0 -> all registers 0, state_o=0, wr_ready_o=1, fifo_rd_en_o=0.
- Throttle set: enable_i=1, rd_ready_i=0, wr_req_i held high -> 16 writes accepted. throttle_o=1 and wr_ready_o=0 from the cycle after the 16th write. fill_count_o holds at 16.
- Release and start: from the throttle-set end state, set rd_ready_i=1 with no writes -> state_o=2 and reads proceed. throttle_o clears on the edge where the count reaches 12. frames_sent_o=1 after 4 reads.
- Prime threshold: write 7 words with enable_i=1 -> state_o stays PRIME. On the 8th write, state_o=2 on the next edge and fifo_rd_en_o=1 in that cycle.
- Low watermark and stalls: from count 8 in STREAM, drive fifo_empty_i=1 for 3 cycles mid-frame -> no reads, wpos held. After 4 reads total, the count is 4 and the FSM returns to PRIME. Writing and reading in the same cycle leaves fill_count_o unchanged.
- Enable drop: drop enable_i after the 2nd word of a frame -> the remaining 2 words are still read, then state_o=0. Asserting reset mid-frame clears wpos and fill_count_o.
